// File: rtl/checkpoint_ctrl.sv
// Checkpoint controller for the speculative register file: allocates checkpoint
// slots per branch, retires them in order and issues one-cycle rollbacks.
module checkpoint_ctrl #(
  parameter int name_width = 1,
  parameter int idx_width  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BR_VALID,
  output logic                  BR_READY,
  output logic [idx_width-1:0]  BR_ID,
  input  logic                  RES_VALID,
  input  logic [idx_width-1:0]  RES_ID,
  input  logic                  RES_MISPRED,
  output logic                  RES_READY,
  output logic                  CHK_E,
  input  logic [name_width-1:0] CHK_IN,
  output logic                  ROLLBK_E,
  output logic                  DO_ROLL,
  output logic                  DO_REL,
  output logic [name_width-1:0] ROLLBK_OUT,
  output logic                  FLUSH,
  output logic [idx_width:0]    COUNT
);

  localparam int DEPTH = 2 ** idx_width;
  localparam logic [idx_width:0] DEPTH_C = (idx_width + 1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, ROLL = 1'b1} state_t;

  state_t                state_r, state_next_s;
  logic [name_width-1:0] name_r [DEPTH];
  logic [DEPTH-1:0]      valid_r, done_r, valid_next_s, done_next_s;
  logic [DEPTH-1:0]      head_oh_s, tail_oh_s, res_oh_s, squash_s;
  logic [idx_width-1:0]  head_r, tail_r, head_next_s, tail_next_s, koff_s;
  logic [idx_width:0]    count_r, count_next_s;
  logic [name_width-1:0] rb_name_r;
  logic                  run_s, slot_live_s, release_s, correct_s, mispred_s;
  logic                  br_ready_s, accept_s;

  // Event decode and next-value computation for the slot table
  always_comb begin
    run_s       = (state_r == RUN);
    slot_live_s = valid_r[RES_ID] && !done_r[RES_ID];
    release_s   = run_s && valid_r[head_r] && done_r[head_r];
    correct_s   = run_s && RES_VALID && !RES_MISPRED && slot_live_s;
    mispred_s   = run_s && RES_VALID && RES_MISPRED && slot_live_s;
    br_ready_s  = run_s && (count_r != DEPTH_C) && !(RES_VALID && RES_MISPRED);
    accept_s    = BR_VALID && br_ready_s;
    head_oh_s   = release_s ? (DEPTH'(1'b1) << head_r) : '0;
    tail_oh_s   = accept_s  ? (DEPTH'(1'b1) << tail_r) : '0;
    res_oh_s    = correct_s ? (DEPTH'(1'b1) << RES_ID) : '0;
    head_next_s = head_r + idx_width'(release_s);
    koff_s      = RES_ID - head_r;
    // Squash k and everything younger: age is the distance from head
    for (int i = 0; i < DEPTH; i++) begin
      squash_s[i] = mispred_s && ((idx_width'(i) - head_r) >= koff_s);
    end
    valid_next_s = (valid_r & ~head_oh_s & ~squash_s) | tail_oh_s;
    done_next_s  = (done_r & ~head_oh_s & ~squash_s & ~tail_oh_s) | res_oh_s;
    if (mispred_s) begin
      tail_next_s  = RES_ID;
      count_next_s = {1'b0, RES_ID - head_next_s};
    end else begin
      tail_next_s  = tail_r + idx_width'(accept_s);
      count_next_s = count_r + (idx_width + 1)'(accept_s) - (idx_width + 1)'(release_s);
    end
  end

  // FSM next state and RF command outputs
  always_comb begin
    state_next_s = state_r;
    ROLLBK_E     = 1'b0;
    DO_ROLL      = 1'b0;
    DO_REL       = 1'b0;
    FLUSH        = 1'b0;
    ROLLBK_OUT   = '0;
    case (state_r)
      RUN: begin
        if (mispred_s) begin
          state_next_s = ROLL;
        end else begin
          state_next_s = RUN;
        end
        if (release_s) begin
          ROLLBK_E   = 1'b1;
          DO_REL     = 1'b1;
          ROLLBK_OUT = name_r[head_r];
        end else begin
          ROLLBK_OUT = '0;
        end
      end
      ROLL: begin
        state_next_s = RUN;
        ROLLBK_E     = 1'b1;
        DO_ROLL      = 1'b1;
        FLUSH        = 1'b1;
        ROLLBK_OUT   = rb_name_r;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Slot table, pointers and latched rollback name
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_r   <= '0;
      done_r    <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      rb_name_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        name_r[i] <= '0;
      end
    end else begin
      valid_r <= valid_next_s;
      done_r  <= done_next_s;
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      count_r <= count_next_s;
      if (accept_s) begin
        name_r[tail_r] <= CHK_IN;
      end
      if (mispred_s) begin
        rb_name_r <= name_r[RES_ID];
      end
    end
  end

  assign BR_READY  = br_ready_s;
  assign BR_ID     = tail_r;
  assign RES_READY = run_s;
  assign CHK_E     = accept_s;
  assign COUNT     = count_r;

endmodule

// File: doc/checkpoint_ctrl.md
# checkpoint_ctrl

Checkpoint controller that drives the checkpoint and rollback ports of the speculative register file, `CheckpointBypassRF`. It sits between branch issue/resolve in the pipeline and the register file. On each accepted branch it takes a checkpoint name and stores it in a circular slot table. On resolution it issues either a release (DO_REL) or a rollback (DO_ROLL). A rollback squashes every younger checkpoint and pulses a pipeline flush.

## Interface
Parameters:
- name_width, 1: width of RF checkpoint names (matches RF name_width)
- idx_width, 2: slot index width; depth = 2**idx_width checkpoints

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- BR_VALID  in  1  branch requests a checkpoint
- BR_READY  out  1  checkpoint can be accepted this cycle
- BR_ID  out  idx_width  slot assigned to the accepted branch (= tail)
- RES_VALID  in  1  branch resolution
- RES_ID  in  idx_width  slot being resolved
- RES_MISPRED  in  1  1 = mispredicted, 0 = correct
- RES_READY  out  1  resolution accepted this cycle
- CHK_E  out  1  to RF CHK_E
- CHK_IN  in  name_width  from RF CHK_OUT
- ROLLBK_E  out  1  to RF ROLLBK_E
- DO_ROLL  out  1  to RF DO_ROLL
- DO_REL  out  1  to RF DO_REL
- ROLLBK_OUT  out  name_width  to RF ROLLBK_IN
- FLUSH  out  1  pipeline squash pulse
- COUNT  out  idx_width+1  live checkpoints

## Operation
- State per slot: name, valid, done. Pointers: head, tail (idx_width, wrap mod depth). count is 0..depth.
- FSM has two states, RUN and ROLL. Reset puts it in RUN with head = tail = count = 0 and all valid/done = 0.
- BR_READY = RUN && count != depth && !(RES_VALID && RES_MISPRED && RES_READY).
- Accept (BR_VALID && BR_READY):
  - CHK_E = 1 combinationally.
  - name[tail] <= CHK_IN, valid[tail] <= 1, done[tail] <= 0.
  - tail++, count++.
- RES_READY = (state == RUN).
- Correct resolve of a valid, not-done slot sets done[RES_ID] <= 1.
- Resolve of an invalid or already-done slot is ignored, with no state change.
- Release, in RUN only, is a function of registers only:
  - Triggers when valid[head] && done[head].
  - Drives ROLLBK_E = 1, DO_REL = 1, DO_ROLL = 0, ROLLBK_OUT = name[head].
  - Next cycle: valid[head] <= 0, head++, count--. At most one release per cycle.
- Mispredict resolve of valid slot k:
  - Latch rb_name <= name[k].
  - Clear valid/done for k and every slot younger than k, up to tail.
  - tail <= k, count <= (k - head_next) mod depth.
  - Go to ROLL.
- ROLL lasts exactly one cycle, then returns to RUN:
  - ROLLBK_E = 1, DO_ROLL = 1, DO_REL = 0, ROLLBK_OUT = rb_name, FLUSH = 1.
  - BR_READY = 0, RES_READY = 0, no release.
- Simultaneous events:
  - An accept plus a correct resolve in the same cycle are both applied.
  - A release plus a mispredict in the same cycle are both applied. head_next is used for count, and k != head because head is done.
  - count counts an accept (+1) and a release (-1) in the same cycle, so count is unchanged.
- ROLLBK_E/DO_* are never asserted together with DO_REL = DO_ROLL = 1.

## Timing
- Reset (RST = 0, asynchronous), outputs:
  - BR_READY = 1 once RST deasserts; BR_ID = 0.
  - RES_READY = 1, ROLLBK_E = DO_ROLL = DO_REL = 0, FLUSH = 0, COUNT = 0, ROLLBK_OUT = 0.
  - CHK_E follows BR_VALID && BR_READY.
- CHK_E and BR_ID are combinational in the accept cycle, and CHK_IN is sampled that cycle.
- Rollback is driven exactly 1 cycle after mispredict acceptance. FLUSH is a 1-cycle pulse in that cycle.
- Earliest release is 1 cycle after the correct resolve of the head slot.
- A full table (count == depth) blocks accepts until a release retires. Wrap of head/tail at depth-1 -> 0 is seamless.
- Reset asserted mid-ROLL aborts the rollback. No RF rollback is issued after reset.

## Test plan
- Reset, then BR_VALID for 4 cycles with CHK_IN = 1,2,3,0 (depth 4, name_width 2):
  - BR_ID 0,1,2,3; COUNT = 4; BR_READY = 0 in the 5th cycle.
- With slots 0..3 live, correct-resolve slot 0:
  - Next cycle ROLLBK_E = 1, DO_REL = 1, ROLLBK_OUT = 1.
  - Then COUNT = 3 and BR_READY = 1.
- Correct-resolve slots 2 then 1 (out of order):
  - Releases come out in order: slot 1 (name 2), then slot 2 (name 3), on consecutive cycles.
- Mispredict slot 1 with slots 0..3 live:
  - Next cycle: DO_ROLL = 1, ROLLBK_OUT = 2, FLUSH = 1, BR_READY = 0.
  - Then COUNT = 1 and the next BR_ID = 1.
- Wrap: after 6 accept/release pairs, BR_ID sequence is 0,1,2,3,0,1 and COUNT never exceeds 1. Resolve of an invalid slot causes no ROLLBK_E.
- Assert RST in the ROLL cycle:
  - All outputs return to reset values immediately; COUNT = 0; no DO_ROLL after release.
